// File: rtl/regfile_mp.sv
// regfile_mp - parametrised multi-port general-purpose register file.
//
// NR combinational read ports, NW write ports (higher port index wins on an
// address collision), a per-register pending scoreboard for hazard detection
// and an optional same-cycle write-to-read bypass.  Storage has no flop
// reset; after rst a sweep writes zero into every entry, one per cycle, so
// the array can map onto distributed RAM.
//
// Optional feature macro: REGFILE_MP_BYPASS_EN
//   defined   : committing write data forwards to matching read ports and
//               masks rd_pend for that register.
//   undefined : reads see the array only (old value in the write cycle).
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset, restarts the clear sweep
//   we        - [NW] write enable per port
//   wa        - [NW*AW] write addresses, port i at [i*AW +: AW]
//   wd        - [NW*DW] write data, port i at [i*DW +: DW]
//   ra        - [NR*AW] read addresses, port j at [j*AW +: AW]
//   rd        - [NR*DW] combinational read data
//   rd_pend   - [NR] read register has an outstanding producer
//   sb_set    - mark register sb_addr pending (instruction issue)
//   sb_addr   - [AW] scoreboard set address
//   init_busy - clear sweep in progress; writes and sets ignored
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NR       = 2,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NW-1:0]    we,
  input  logic [NW*AW-1:0] wa,
  input  logic [NW*DW-1:0] wd,
  input  logic [NR*AW-1:0] ra,
  output logic [NR*DW-1:0] rd,
  output logic [NR-1:0]    rd_pend,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_addr,
  output logic             init_busy
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_reg, state_next;
  // One bit wider than an address so the pointer never wraps at DEPTH-1.
  logic [AW:0]      clr_ptr_reg, clr_ptr_next;
  logic [DEPTH-1:0] busy_reg, busy_next;
  logic [DW-1:0]    mem [DEPTH];
  logic [NW-1:0]    wcommit;

  assign init_busy = (state_reg == CLEAR);

  // A write commits only in READY and never to r0 when it is hardwired.
  for (genvar gi = 0; gi < NW; gi++) begin : g_commit
    assign wcommit[gi] = (state_reg == READY) && we[gi] &&
                         !((ZERO_REG != 0) && (wa[gi*AW +: AW] == '0));
  end

  // Sweep FSM: the edge that clears entry DEPTH-1 enters READY.
  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    if (state_reg == CLEAR) begin
      clr_ptr_next = clr_ptr_reg + (AW+1)'(1);
      if (clr_ptr_reg == (AW+1)'(DEPTH-1))
        state_next = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  // Storage: no reset on purpose.  Ascending port order makes the highest
  // index the last assignment, so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (!rst && state_reg == CLEAR)
      mem[clr_ptr_reg[AW-1:0]] <= '0;
    for (int i = 0; i < NW; i++) begin
      if (wcommit[i])
        mem[wa[i*AW +: AW]] <= wd[i*DW +: DW];
    end
  end

  // Scoreboard: the issue set is applied after the write clears, so a new
  // producer issued in the same cycle as a completing one stays pending.
  always_comb begin
    busy_next = busy_reg;
    for (int i = 0; i < NW; i++) begin
      if (wcommit[i])
        busy_next[wa[i*AW +: AW]] = 1'b0;
    end
    if ((state_reg == READY) && sb_set &&
        !((ZERO_REG != 0) && (sb_addr == '0)))
      busy_next[sb_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      busy_reg <= '0;
    else
      busy_reg <= busy_next;
  end

  // Read ports.
  for (genvar gi = 0; gi < NR; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
    logic          pend;
    logic          hit;

    assign addr = ra[gi*AW +: AW];

    always_comb begin
      hit = 1'b0;
      val = mem[addr];
`ifdef REGFILE_MP_BYPASS_EN
      // Highest-index committing write to this address supplies the data.
      for (int i = 0; i < NW; i++) begin
        if (wcommit[i] && (wa[i*AW +: AW] == addr)) begin
          hit = 1'b1;
          val = wd[i*DW +: DW];
        end
      end
`endif
      pend = busy_reg[addr] && !hit;
      if ((state_reg == CLEAR) || ((ZERO_REG != 0) && (addr == '0))) begin
        val  = '0;
        pend = 1'b0;
      end
    end

    assign rd[gi*DW +: DW] = val;
    assign rd_pend[gi]     = pend;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp (default parameters: DW=32, AW=5, NR=2, NW=2,
// ZERO_REG=1).  Works with or without REGFILE_MP_BYPASS_EN defined.
//
// The stimulus process drives one cycle at a time; before each edge it asks a
// behavioural model (plain arrays + a sweep countdown) what the outputs must
// be and pushes those expectations into a queue.  Directed scenarios push
// extra entries holding hand-derived constants.  A monitor on the falling
// edge pops every queued entry and compares it with the DUT outputs.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] wa;
  logic [NW*DW-1:0] wd;
  logic [NR*AW-1:0] ra;
  logic [NR*DW-1:0] rd;
  logic [NR-1:0]    rd_pend;
  logic             sb_set;
  logic [AW-1:0]    sb_addr;
  logic             init_busy;

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra(ra), .rd(rd),
    .rd_pend(rd_pend), .sb_set(sb_set), .sb_addr(sb_addr),
    .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            port;
    logic [DW-1:0] rd;
    logic          pend;
    logic          ib;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   txn      = 0;

  // Reference model.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];
  bit            m_ready;
  int            sweep_left;

  function automatic bit commits(int i);
    return m_ready && we[i] && (wa[i*AW +: AW] != 0);
  endfunction

  // Monitor: compare every expectation queued for this cycle.
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks += 3;
      if (rd[e.port*DW +: DW] !== e.rd) begin
        n_fail++;
        $display("FAIL %s rd[%0d]: got %h expected %h", e.name, e.port,
                 rd[e.port*DW +: DW], e.rd);
      end
      if (rd_pend[e.port] !== e.pend) begin
        n_fail++;
        $display("FAIL %s rd_pend[%0d]: got %b expected %b", e.name, e.port,
                 rd_pend[e.port], e.pend);
      end
      if (init_busy !== e.ib) begin
        n_fail++;
        $display("FAIL %s init_busy: got %b expected %b", e.name,
                 init_busy, e.ib);
      end
    end
  end

  task automatic idle();
    we = '0; sb_set = 1'b0; sb_addr = '0;
  endtask

  task automatic set_wr(int i, int a, logic [DW-1:0] d);
    we[i] = 1'b1;
    wa[i*AW +: AW] = AW'(a);
    wd[i*DW +: DW] = d;
  endtask

  task automatic set_rd(int j, int a);
    ra[j*AW +: AW] = AW'(a);
  endtask

  // Hand-derived expectation for the current cycle (always in READY).
  task automatic expect_const(string name, int port, logic [DW-1:0] v,
                              logic p);
    exp_t e;
    e.name = name; e.port = port; e.rd = v; e.pend = p; e.ib = 1'b0;
    sb_q.push_back(e);
  endtask

  // One clock cycle with the inputs currently driven.
  task automatic step();
    for (int j = 0; j < NR; j++) begin
      exp_t e;
      int a;
      a = int'(ra[j*AW +: AW]);
      e.name = "model"; e.port = j; e.ib = !m_ready;
      e.rd = m_mem[a]; e.pend = m_busy[a];
      if (BYP) begin
        for (int i = 0; i < NW; i++) begin
          if (commits(i) && int'(wa[i*AW +: AW]) == a) begin
            e.rd = wd[i*DW +: DW]; e.pend = 1'b0;
          end
        end
      end
      if (!m_ready || a == 0) begin
        e.rd = '0; e.pend = 1'b0;
      end
      sb_q.push_back(e);
    end
    $display("txn %0d rst=%0b we=%b wa=%h wd=%h ra=%h sb=%0b@%0d", txn, rst,
             we, wa, wd, ra, sb_set, sb_addr);
    txn++;
    @(posedge clk);
    if (rst) begin
      m_ready = 1'b0; sweep_left = DEPTH;
      for (int r = 0; r < DEPTH; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
    end else if (!m_ready) begin
      sweep_left--;
      if (sweep_left == 0) m_ready = 1'b1;
    end else begin
      for (int i = 0; i < NW; i++) begin
        if (commits(i)) begin
          m_mem[wa[i*AW +: AW]]  = wd[i*DW +: DW];
          m_busy[wa[i*AW +: AW]] = 1'b0;
        end
      end
      if (sb_set && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    end
    #1;
  endtask

  initial begin
    m_ready = 1'b0; sweep_left = DEPTH;
    for (int r = 0; r < DEPTH; r++) begin m_mem[r] = '0; m_busy[r] = 1'b0; end
    rst = 1'b1; idle(); wa = '0; wd = '0; ra = '0;
    @(posedge clk); #1;
    step(); step();

    // Reset sweep: write in the release cycle is ignored.
    rst = 1'b0;
    set_wr(0, 3, 32'hDEADBEEF); set_rd(0, 3); set_rd(1, 3);
    step();
    idle();
    for (int c = 0; c < DEPTH-1; c++) step();
    expect_const("rst_write_ignored", 0, 32'h0, 1'b0);
    step();
    set_wr(0, 3, 32'h12345678);
    step();
    idle();
    expect_const("ready_readback", 0, 32'h12345678, 1'b0);
    step();

    // Write-port priority.
    set_wr(0, 7, 32'h1111); set_wr(1, 7, 32'h2222); set_rd(0, 7);
    expect_const("prio_same_cycle", 0, BYP ? 32'h2222 : 32'h0, 1'b0);
    step();
    idle();
    expect_const("prio_next_cycle", 0, 32'h2222, 1'b0);
    step();

    // Zero register.
    set_wr(1, 0, 32'hFFFFFFFF); sb_set = 1'b1; sb_addr = '0;
    set_rd(0, 0); set_rd(1, 0);
    expect_const("zero_reg_p0", 0, 32'h0, 1'b0);
    expect_const("zero_reg_p1", 1, 32'h0, 1'b0);
    step();
    idle();
    expect_const("zero_reg_after_p0", 0, 32'h0, 1'b0);
    expect_const("zero_reg_after_p1", 1, 32'h0, 1'b0);
    step();

    // Scoreboard.
    set_rd(0, 9); sb_set = 1'b1; sb_addr = AW'(9);
    step();
    idle();
    expect_const("sb_pending", 0, 32'h0, 1'b1);
    step();
    set_wr(0, 9, 32'h99);
    expect_const("sb_write_same", 0, BYP ? 32'h99 : 32'h0, !BYP);
    step();
    idle();
    expect_const("sb_write_next", 0, 32'h99, 1'b0);
    step();
    set_wr(1, 9, 32'h77); sb_set = 1'b1; sb_addr = AW'(9);
    step();
    idle();
    expect_const("sb_set_beats_clear", 0, 32'h77, 1'b1);
    step();

    // Same-cycle write/read of register 5.
    set_wr(0, 5, 32'hA);
    step();
    set_wr(1, 5, 32'hB); set_rd(1, 5);
    expect_const("rw_same_cycle", 1, BYP ? 32'hB : 32'hA, 1'b0);
    step();
    idle();
    expect_const("rw_next_cycle", 1, 32'hB, 1'b0);
    step();

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      idle();
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NW; i++) begin
        int a;
        a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3))
                                        : int'($urandom_range(0, DEPTH-1));
        we[i] = ($urandom_range(0, 1) == 1);
        wa[i*AW +: AW] = AW'(a);
        wd[i*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NR; j++) begin
        if ($urandom_range(0, 2) == 0) ra[j*AW +: AW] = wa[AW-1:0];
        else ra[j*AW +: AW] = AW'($urandom_range(0, DEPTH-1));
      end
      sb_set  = ($urandom_range(0, 2) == 0);
      sb_addr = ($urandom_range(0, 1) == 0) ? wa[AW +: AW]
                                            : AW'($urandom_range(0, DEPTH-1));
      step();
    end
    rst = 1'b0; idle();

    // Fill some registers so the mid-sweep reset has something to erase.
    for (int r = 1; r < DEPTH; r += 2) begin
      idle(); set_wr(0, r, 32'hC0DE0000 | r); set_wr(1, r - 1, 32'hFACE0000 | r);
      step();
    end
    idle();

    // Mid-sweep reset.
    rst = 1'b1; step();
    rst = 1'b0;
    for (int c = 0; c < 10; c++) step();
    rst = 1'b1; step();
    rst = 1'b0;
    for (int c = 0; c < DEPTH; c++) step();
    for (int r = 0; r < DEPTH; r += 2) begin
      set_rd(0, r); set_rd(1, r + 1);
      expect_const("post_sweep_zero", 0, 32'h0, 1'b0);
      expect_const("post_sweep_zero", 1, 32'h0, 1'b0);
      step();
    end

    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
